// File: rtl/keypad_scan_ctrl_if.sv
// Keypad scan controller port bundle: raw columns in, row drive and key strobe out.
// master = scan controller side, slave = keypad / display side.
interface keypad_scan_ctrl_if;
    logic [3:0] cols;
    logic [3:0] key_row;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  cols,
        output key_row,
        output key,
        output key_valid,
        output key_held
    );

    modport slave (
        output cols,
        input  key_row,
        input  key,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: one active-low row at a time, debounced single-key press -> one-cycle key_valid + hex code.
// Optional auto-repeat while held is enabled by defining KEY_REPEAT_EN.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV       = 48000,
    parameter int DEBOUNCE_SCANS = 20,
    parameter int REPEAT_DLY     = 500,
    parameter int REPEAT_PER     = 100
) (
    input  logic               i_clk,
    input  logic               i_reset,
    keypad_scan_ctrl_if.master if_kp
);

    localparam int MAX_AB = (SCAN_DIV > DEBOUNCE_SCANS) ? SCAN_DIV : DEBOUNCE_SCANS;
    localparam int MAX_CD = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] C_DIV_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] C_DEB_LAST = CW'(DEBOUNCE_SCANS - 1);
    localparam logic [CW-1:0] C_ONE      = CW'(1);
    localparam logic [CW-1:0] C_MAX      = '1;

    typedef enum logic [1:0] {
        S_SCAN      = 2'd0,
        S_DEB_PRESS = 2'd1,
        S_HELD      = 2'd2,
        S_DEB_REL   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_cols_meta;
    logic [3:0]    r_cols_sync;
    logic [CW-1:0] r_div;
    logic [CW-1:0] r_deb_cnt;
    logic [3:0]    r_key_row;
    logic [3:0]    r_cand_cols;
    logic [1:0]    r_cand_row;
    logic [1:0]    r_cand_col;
    logic [3:0]    r_key;
    logic          r_key_valid;
    logic          r_key_held;
    logic          r_lock;
    logic [1:0]    r_clean_cnt;

    logic       w_sample;
    logic       w_one_low;
    logic [1:0] w_low_idx;
    logic [1:0] w_row_idx;
    logic       w_match;
    logic       w_cand_hi;
    logic       w_deb_done;
    logic       w_rotate;
    logic       w_latch;
    logic       w_cnt_inc;
    logic       w_rel_start;
    logic       w_accept;
    logic       w_release;
    logic       w_repeat_strobe;

    function automatic logic [3:0] f_key_code(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'h0:    f_key_code = 4'h1;
            4'h1:    f_key_code = 4'h2;
            4'h2:    f_key_code = 4'h3;
            4'h3:    f_key_code = 4'hA;
            4'h4:    f_key_code = 4'h4;
            4'h5:    f_key_code = 4'h5;
            4'h6:    f_key_code = 4'h6;
            4'h7:    f_key_code = 4'hB;
            4'h8:    f_key_code = 4'h7;
            4'h9:    f_key_code = 4'h8;
            4'hA:    f_key_code = 4'h9;
            4'hB:    f_key_code = 4'hC;
            4'hC:    f_key_code = 4'hE;
            4'hD:    f_key_code = 4'h0;
            4'hE:    f_key_code = 4'hF;
            default: f_key_code = 4'hD;
        endcase
    endfunction

    // Idle columns float high, so the synchronizer resets to "no key".
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cols_meta <= 4'hF;
            r_cols_sync <= 4'hF;
        end else begin
            r_cols_meta <= if_kp.cols;
            r_cols_sync <= r_cols_meta;
        end
    end

    always_comb begin
        w_one_low = 1'b1;
        w_low_idx = 2'd0;
        case (r_cols_sync)
            4'b1110: w_low_idx = 2'd0;
            4'b1101: w_low_idx = 2'd1;
            4'b1011: w_low_idx = 2'd2;
            4'b0111: w_low_idx = 2'd3;
            default: w_one_low = 1'b0;
        endcase
        case (r_key_row)
            4'b1101: w_row_idx = 2'd1;
            4'b1011: w_row_idx = 2'd2;
            4'b0111: w_row_idx = 2'd3;
            default: w_row_idx = 2'd0;
        endcase
    end

    assign w_sample   = (r_div == C_DIV_LAST);
    assign w_match    = (r_cols_sync == r_cand_cols);
    assign w_cand_hi  = r_cols_sync[r_cand_col];
    assign w_deb_done = (r_deb_cnt >= C_DEB_LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_SCAN;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_sample) begin
            case (r_state)
                S_SCAN:      if (w_one_low && !r_lock) w_state_nxt = S_DEB_PRESS;
                S_DEB_PRESS: if (!w_match)             w_state_nxt = S_SCAN;
                             else if (w_deb_done)      w_state_nxt = S_HELD;
                S_HELD:      if (w_cand_hi)            w_state_nxt = S_DEB_REL;
                default:     if (!w_cand_hi)           w_state_nxt = S_HELD;
                             else if (w_deb_done)      w_state_nxt = S_SCAN;
            endcase
        end
    end

    always_comb begin
        w_rotate    = 1'b0;
        w_latch     = 1'b0;
        w_cnt_inc   = 1'b0;
        w_rel_start = 1'b0;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        if (w_sample) begin
            case (r_state)
                S_SCAN: begin
                    w_latch  = w_one_low && !r_lock;
                    w_rotate = !(w_one_low && !r_lock);
                end
                S_DEB_PRESS: begin
                    w_rotate  = !w_match;
                    w_accept  = w_match && w_deb_done;
                    w_cnt_inc = w_match && !w_deb_done;
                end
                S_HELD: w_rel_start = w_cand_hi;
                default: begin
                    w_release = w_cand_hi && w_deb_done;
                    w_rotate  = w_cand_hi && w_deb_done;
                    w_cnt_inc = w_cand_hi && !w_deb_done;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_div       <= '0;
            r_deb_cnt   <= '0;
            r_key_row   <= 4'b1110;
            r_cand_cols <= 4'hF;
            r_cand_row  <= 2'd0;
            r_cand_col  <= 2'd0;
            r_key       <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_div       <= w_sample ? '0 : r_div + C_ONE;
            r_key_valid <= w_accept || w_repeat_strobe;
            if (w_rotate)
                r_key_row <= {r_key_row[2:0], r_key_row[3]};
            if (w_latch) begin
                r_cand_cols <= r_cols_sync;
                r_cand_row  <= w_row_idx;
                r_cand_col  <= w_low_idx;
            end
            if (w_latch || w_rel_start)
                r_deb_cnt <= C_ONE;
            else if (w_cnt_inc && (r_deb_cnt != C_MAX))
                r_deb_cnt <= r_deb_cnt + C_ONE;
            if (w_accept) begin
                r_key      <= f_key_code(r_cand_row, r_cand_col);
                r_key_held <= 1'b1;
            end else if (w_release) begin
                r_key_held <= 1'b0;
            end
        end
    end

    // A key still down in the row at release was pressed during HELD; it stays
    // unreported until a full clean pass over all four rows has been seen.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_lock      <= 1'b0;
            r_clean_cnt <= 2'd0;
        end else if (w_release) begin
            r_lock      <= (r_cols_sync != 4'hF);
            r_clean_cnt <= 2'd0;
        end else if (r_lock && w_sample && (r_state == S_SCAN)) begin
            if (r_cols_sync != 4'hF) begin
                r_clean_cnt <= 2'd0;
            end else if (r_clean_cnt == 2'd3) begin
                r_lock      <= 1'b0;
                r_clean_cnt <= 2'd0;
            end else begin
                r_clean_cnt <= r_clean_cnt + 2'd1;
            end
        end
    end

`ifdef KEY_REPEAT_EN
    localparam logic [CW-1:0] C_RDLY      = CW'(REPEAT_DLY);
    localparam logic [CW-1:0] C_RDLY_LAST = CW'(REPEAT_DLY - 1);
    localparam logic [CW-1:0] C_RPER_LAST = CW'(REPEAT_PER - 1);

    logic [CW-1:0] r_rep_cnt;
    logic [CW-1:0] r_per_cnt;
    logic          w_rep_tick;

    // Count survives a bounce back from DEB_REL; only a new accept or a real release clears it.
    assign w_rep_tick      = w_sample && (r_state == S_HELD) && !w_cand_hi;
    assign w_repeat_strobe = w_rep_tick &&
                             ((r_rep_cnt == C_RDLY_LAST) ||
                              ((r_rep_cnt == C_RDLY) && (r_per_cnt >= C_RPER_LAST)));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rep_cnt <= '0;
            r_per_cnt <= '0;
        end else if (w_accept || w_release) begin
            r_rep_cnt <= '0;
            r_per_cnt <= '0;
        end else if (w_rep_tick) begin
            if (r_rep_cnt < C_RDLY)
                r_rep_cnt <= r_rep_cnt + C_ONE;
            else if (r_per_cnt >= C_RPER_LAST)
                r_per_cnt <= '0;
            else
                r_per_cnt <= r_per_cnt + C_ONE;
        end
    end
`else
    assign w_repeat_strobe = 1'b0;
`endif

    assign if_kp.key_row   = r_key_row;
    assign if_kp.key       = r_key;
    assign if_kp.key_valid = r_key_valid;
    assign if_kp.key_held  = r_key_held;

endmodule
